// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the common-bus arbitration path: requester count,
// FIFO code width, grant FSM states and code decoding.
package bus_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 4;
  localparam int ID_W   = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    LATCH   = 3'd2,
    CHECK   = 3'd3,
    GRANT   = 3'd4,
    RELEASE = 3'd5
  } state_e;

  // Codes 1..N_REQ name a requester; 0 and anything above N_REQ are garbage entries.
  function automatic logic code_is_valid(input logic [CODE_W-1:0] code);
    return (code != {CODE_W{1'b0}}) && (code <= CODE_W'(N_REQ));
  endfunction

  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] oh;
    if (code_is_valid(code)) begin
      oh = N_REQ'(1) << (code - CODE_W'(1));
    end else begin
      oh = {N_REQ{1'b0}};
    end
    return oh;
  endfunction

  function automatic logic [ID_W-1:0] code_to_id(input logic [CODE_W-1:0] code);
    return ID_W'(code - CODE_W'(1));
  endfunction

endpackage

// File: rtl/bus_grant_ctrl_hold_timer.sv
// Grant hold timer: restarts on load, counts while enabled and flags the last
// permitted cycle of a grant.
module hold_timer #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_r;

  // Hold counter: cleared on load, counts while enabled, parks at MAX_HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != CNT_W'(MAX_HOLD))) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // First grant cycle sees count 0, so this fires on the MAX_HOLD-th held cycle.
  assign expire = en && (cnt_r == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/bus_grant_ctrl.sv
// Bus grant controller: pops requester codes from the request FIFO in arrival order,
// confirms the request is still live and grants the shared bus until release or timeout.
module bus_grant_ctrl
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [CODE_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              gnt_valid,
  output logic              timeout,
  output logic              drop
);

  state_e              state_r, state_nxt_s;
  logic [CODE_W-1:0]   code_r, code_nxt_s;
  logic [N_REQ-1:0]    gnt_r, gnt_nxt_s;
  logic [ID_W-1:0]     gnt_id_r, gnt_id_nxt_s;
  logic                gnt_valid_r, gnt_valid_nxt_s;
  logic                rd_en_r, rd_en_nxt_s;
  logic                timeout_r, timeout_nxt_s;
  logic                drop_r, drop_nxt_s;
  logic                load_s;
  logic                hold_en_s;
  logic                expire_s;
  logic [N_REQ-1:0]    code_oh_s;
  logic                code_ok_s;
  logic                code_live_s;
  logic                owner_live_s;

  assign code_oh_s    = code_to_onehot(code_r);
  assign code_ok_s    = code_is_valid(code_r);
  assign code_live_s  = |(req & code_oh_s);
  assign owner_live_s = req[gnt_id_r];
  assign hold_en_s    = (state_r == GRANT);

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .en     (hold_en_s),
    .expire (expire_s)
  );

  // Next-state and next-output decode; pulses default low, grant state holds.
  always_comb begin
    state_nxt_s     = state_r;
    code_nxt_s      = code_r;
    gnt_nxt_s       = gnt_r;
    gnt_id_nxt_s    = gnt_id_r;
    gnt_valid_nxt_s = gnt_valid_r;
    rd_en_nxt_s     = 1'b0;
    timeout_nxt_s   = 1'b0;
    drop_nxt_s      = 1'b0;
    load_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt_s = POP;
          rd_en_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      POP: begin
        state_nxt_s = LATCH;
      end
      LATCH: begin
        code_nxt_s  = fifo_data;
        state_nxt_s = CHECK;
      end
      CHECK: begin
        if (!code_ok_s || !code_live_s) begin
          drop_nxt_s  = 1'b1;
          state_nxt_s = RELEASE;
        end else begin
          gnt_nxt_s       = code_oh_s;
          gnt_id_nxt_s    = code_to_id(code_r);
          gnt_valid_nxt_s = 1'b1;
          load_s          = 1'b1;
          state_nxt_s     = GRANT;
        end
      end
      GRANT: begin
        // A request drop wins over a coincident expiry: that is a clean release.
        if (!owner_live_s) begin
          gnt_nxt_s       = {N_REQ{1'b0}};
          gnt_id_nxt_s    = {ID_W{1'b0}};
          gnt_valid_nxt_s = 1'b0;
          state_nxt_s     = RELEASE;
        end else if (expire_s) begin
          gnt_nxt_s       = {N_REQ{1'b0}};
          gnt_id_nxt_s    = {ID_W{1'b0}};
          gnt_valid_nxt_s = 1'b0;
          timeout_nxt_s   = 1'b1;
          state_nxt_s     = RELEASE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      RELEASE: begin
        gnt_nxt_s       = {N_REQ{1'b0}};
        gnt_id_nxt_s    = {ID_W{1'b0}};
        gnt_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
      default: begin
        gnt_nxt_s       = {N_REQ{1'b0}};
        gnt_id_nxt_s    = {ID_W{1'b0}};
        gnt_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      code_r      <= {CODE_W{1'b0}};
      gnt_r       <= {N_REQ{1'b0}};
      gnt_id_r    <= {ID_W{1'b0}};
      gnt_valid_r <= 1'b0;
      rd_en_r     <= 1'b0;
      timeout_r   <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      code_r      <= code_nxt_s;
      gnt_r       <= gnt_nxt_s;
      gnt_id_r    <= gnt_id_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
      rd_en_r     <= rd_en_nxt_s;
      timeout_r   <= timeout_nxt_s;
      drop_r      <= drop_nxt_s;
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign gnt        = gnt_r;
  assign gnt_id     = gnt_id_r;
  assign gnt_valid  = gnt_valid_r;
  assign timeout    = timeout_r;
  assign drop       = drop_r;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Scoreboard bench for bus_grant_ctrl: a FIFO/requester environment plus a timing
// model of the service order predicts every grant/drop event and its cycle.
module tb_bus_grant_ctrl;
  import bus_arb_pkg::*;

  localparam int MAXH = 8;
  localparam int CW   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_data = 4'd0;
  logic       fifo_rd_en;
  logic [7:0] req = 8'd0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid, timeout, drop;

  bus_grant_ctrl #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .gnt_valid(gnt_valid), .timeout(timeout), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_gnt;
    logic [7:0] oh;
    logic [2:0] id;
    int         cyc;
    int         len;
    bit         to;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] fifo_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       rd_pending = 1'b0;
  bit         live[8];
  bit         granted[8];
  int         dly[8];
  int         gcnt[8];
  int         free_at = 0;
  bit         mon_en = 1'b0;
  bit         mon_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_pending <= fifo_rd_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of environment: FIFO pop, then requester reaction to the grant.
  task automatic step();
    @(negedge clk);
    if (rd_pending && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    for (int r = 0; r < 8; r++) begin
      if (gnt[r]) begin
        granted[r] = 1'b1;
        req[r]     = (gcnt[r] < dly[r]);
        gcnt[r]++;
      end else if (granted[r]) begin
        granted[r] = 1'b0;
        live[r]    = 1'b0;
        req[r]     = 1'b0;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // Push a code; requester (if live) keeps req for d grant cycles, then drops it.
  task automatic push_entry(input logic [3:0] code, input bit is_live, input int d);
    exp_t e;
    int   s;
    int   r;
    s        = (cyc > free_at) ? cyc : free_at;
    e.cyc    = s + 4;
    e.is_gnt = (code >= 4'd1) && (code <= 4'd8) && is_live;
    e.oh     = 8'd0;
    e.id     = 3'd0;
    e.len    = 0;
    e.to     = 1'b0;
    if (e.is_gnt) begin
      r          = int'(code) - 1;
      e.oh       = 8'd1 << r;
      e.id       = 3'(r);
      e.len      = (d >= MAXH) ? MAXH : d + 1;
      e.to       = (d >= MAXH);
      free_at    = s + 5 + e.len;
      live[r]    = 1'b1;
      dly[r]     = d;
      gcnt[r]    = 0;
      req[r]     = 1'b1;
    end else begin
      free_at = s + 5;
    end
    sb.push_back(e);
    fifo_q.push_back(code);
    fifo_empty = 1'b0;
  endtask

  task automatic flush_env();
    sb.delete();
    fifo_q.delete();
    fifo_empty = 1'b1;
    req        = 8'd0;
    mon_active = 1'b0;
    for (int r = 0; r < 8; r++) begin
      live[r] = 1'b0; granted[r] = 1'b0; gcnt[r] = 0; dly[r] = 0;
    end
  endtask

  function automatic bit any_live();
    bit a = 1'b0;
    for (int r = 0; r < 8; r++) a = a | live[r] | granted[r];
    return a;
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || mon_active || any_live()) && n < 400) begin
      step();
      n++;
    end
    check(name, 32'(n < 400), 32'd1);
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pops on each event.
  initial begin
    logic [7:0] prev_gnt;
    exp_t       cur;
    exp_t       dev;
    int         glen;
    prev_gnt = 8'd0;
    glen     = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("gnt_valid_vs_gnt", 32'(gnt_valid), 32'(gnt != 8'd0));
        check("drop_and_timeout", 32'(drop & timeout), 32'd0);
        check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        if (gnt == 8'd0) check("gnt_id_idle", 32'(gnt_id), 32'd0);
        if (gnt != 8'd0 && prev_gnt == 8'd0) begin
          check("timeout_on_rise", 32'(timeout), 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_grant", 32'(gnt), 32'd0);
          end else begin
            cur = sb.pop_front();
            check("event_is_grant", 32'd1, 32'(cur.is_gnt));
            check("grant_cycle", 32'(cyc), 32'(cur.cyc));
            check("gnt_value", 32'(gnt), 32'(cur.oh));
            check("gnt_id_value", 32'(gnt_id), 32'(cur.id));
            glen       = 1;
            mon_active = 1'b1;
          end
        end else if (gnt != 8'd0) begin
          glen++;
          check("gnt_stable", 32'(gnt), 32'(prev_gnt));
          check("timeout_mid_grant", 32'(timeout), 32'd0);
        end else if (prev_gnt != 8'd0) begin
          if (mon_active) begin
            check("grant_length", 32'(glen), 32'(cur.len));
            check("timeout_flag", 32'(timeout), 32'(cur.to));
          end
          mon_active = 1'b0;
        end else begin
          check("timeout_spurious", 32'(timeout), 32'd0);
        end
        if (drop) begin
          if (sb.size() == 0) begin
            check("unexpected_drop", 32'(drop), 32'd0);
          end else begin
            dev = sb.pop_front();
            check("event_is_drop", 32'd0, 32'(dev.is_gnt));
            check("drop_cycle", 32'(cyc), 32'(dev.cyc));
            check("gnt_on_drop", 32'(gnt), 32'd0);
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst     = 1'b0;
    free_at = cyc;

    // Async reset in the middle of a grant to requester 3.
    push_entry(4'd3, 1'b1, 1000);
    begin
      int n = 0;
      while (gnt !== 8'h04 && n < 20) begin step(); n++; end
    end
    check("t1_gnt_before_reset", 32'(gnt), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("t1_gnt_async_clear", 32'(gnt), 32'd0);
    check("t1_valid_async_clear", 32'(gnt_valid), 32'd0);
    flush_env();
    step();
    step();
    rst     = 1'b0;
    free_at = cyc;
    repeat (4) begin
      step();
      check("t1_no_pop_when_empty", 32'(fifo_rd_en), 32'd0);
    end
    mon_en = 1'b1;

    push_entry(4'd3, 1'b1, 3);
    wait_done("t2_single_drain");

    push_entry(4'd5, 1'b1, 4);
    push_entry(4'd1, 1'b1, 2);
    push_entry(4'd8, 1'b1, 0);
    wait_done("t3_order_drain");

    push_entry(4'd2, 1'b0, 0);
    push_entry(4'd0, 1'b0, 0);
    push_entry(4'd9, 1'b0, 0);
    wait_done("t4_stale_drain");

    push_entry(4'd4, 1'b1, 1000);
    push_entry(4'd6, 1'b1, 2);
    wait_done("t5_timeout_drain");

    push_entry(4'd7, 1'b1, MAXH - 1);
    step();
    push_entry(4'd2, 1'b1, MAXH - 2);
    wait_done("t6_simul_drain");

    for (int b = 0; b < 40; b++) begin
      int nent;
      int perm[8];
      nent = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 0; i < 8; i++) begin
        int j;
        int t;
        j = $urandom_range(i, 7);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < nent; i++) begin
        int         kind;
        int         d;
        logic [3:0] c;
        kind = $urandom_range(0, 99);
        case ($urandom_range(0, 5))
          0:       d = 0;
          1:       d = $urandom_range(1, 4);
          2:       d = MAXH - 2;
          3:       d = MAXH - 1;
          4:       d = MAXH;
          default: d = MAXH + 5;
        endcase
        c = 4'(perm[i] + 1);
        if (kind < 70) begin
          push_entry(c, 1'b1, d);
        end else if (kind < 85) begin
          push_entry(c, 1'b0, d);
        end else begin
          c = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
          push_entry(c, 1'b0, 0);
        end
        if ($urandom_range(0, 1) == 1) step();
      end
      wait_done("rand_drain");
      repeat ($urandom_range(0, 3)) step();
    end

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
